// File: rtl/planificador_solicitudes.sv
// -----------------------------------------------------------------------------
// planificador_solicitudes
// Elevator request scheduler. It keeps a bitmap of pending button codes and
// picks the next instruction for the elevator state machine using SCAN
// ordering: keep moving in the current direction while requests remain ahead,
// otherwise turn around.
//
// Code map (bit k-1 of the bitmap = code k):
//   1..4 cabin buttons for floors 0..3
//   5 S1 (floor 0 up), 6 B2 (floor 1 down), 7 S2 (floor 1 up),
//   8 B3 (floor 2 down), 9 S3 (floor 2 up), 10 B4 (floor 3 down)
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset (drops all pending requests)
//   boton_pres   encoded button code, 0 = none, 1..10 valid, 11..15 ignored
//   LE           1 = memoria may update, 0 = state machine sampling, hold it
//   piso         current floor 0..3
//   accion       motion status from the state machine (informational only)
//   puertas      1 = doors open at piso, serviced requests are cleared
//   memoria      next instruction code (registered)
//   pendientes   pending-request bitmap (registered)
//   n_pendientes number of pending requests (registered)
//   direccion    scheduler direction: 0 idle, 1 up, 2 down (registered)
// -----------------------------------------------------------------------------
module planificador_solicitudes #(
    parameter bit PRIORIDAD_CABINA = 1'b1,
    parameter int ANCHO_COD        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ANCHO_COD-1:0] boton_pres,
    input  logic                 LE,
    input  logic [1:0]           piso,
    input  logic [1:0]           accion,
    input  logic                 puertas,
    output logic [ANCHO_COD-1:0] memoria,
    output logic [9:0]           pendientes,
    output logic [3:0]           n_pendientes,
    output logic [1:0]           direccion
);

    typedef enum logic [1:0] {
        DIR_REPOSO = 2'd0,
        DIR_SUBE   = 2'd1,
        DIR_BAJA   = 2'd2
    } dir_t;

    // Bitmap bits belonging to one floor: its cabin code plus its hall codes.
    function automatic logic [9:0] mascara_piso(input logic [1:0] f);
        logic [9:0] m;
        case (f)
            2'd0:    m = 10'b00_0001_0001;   // codes 1, 5
            2'd1:    m = 10'b00_0110_0010;   // codes 2, 6, 7
            2'd2:    m = 10'b01_1000_0100;   // codes 3, 8, 9
            2'd3:    m = 10'b10_0000_1000;   // codes 4, 10
            default: m = 10'b00_0000_0000;
        endcase
        return m;
    endfunction

    // Instruction code to announce for target floor f. Hall preference follows
    // the current direction; any pending code of the floor is a valid fallback.
    function automatic logic [ANCHO_COD-1:0] codigo_piso(input logic [9:0] pend,
                                                         input logic [1:0] f,
                                                         input logic [1:0] dir);
        logic [ANCHO_COD-1:0] cod_cab, cod_s, cod_b, cod_pri, cod_sec, res;
        logic                 hay_cab, hay_s, hay_b, hay_pri, hay_sec;
        cod_cab = ANCHO_COD'(f) + ANCHO_COD'(1);
        hay_cab = pend[f];
        case (f)
            2'd0: begin
                cod_s = ANCHO_COD'(5);  hay_s = pend[4];
                cod_b = ANCHO_COD'(0);  hay_b = 1'b0;
            end
            2'd1: begin
                cod_s = ANCHO_COD'(7);  hay_s = pend[6];
                cod_b = ANCHO_COD'(6);  hay_b = pend[5];
            end
            2'd2: begin
                cod_s = ANCHO_COD'(9);  hay_s = pend[8];
                cod_b = ANCHO_COD'(8);  hay_b = pend[7];
            end
            2'd3: begin
                cod_s = ANCHO_COD'(0);  hay_s = 1'b0;
                cod_b = ANCHO_COD'(10); hay_b = pend[9];
            end
            default: begin
                cod_s = ANCHO_COD'(0);  hay_s = 1'b0;
                cod_b = ANCHO_COD'(0);  hay_b = 1'b0;
            end
        endcase
        if (dir == DIR_BAJA) begin
            cod_pri = cod_b; hay_pri = hay_b;
            cod_sec = cod_s; hay_sec = hay_s;
        end else begin
            cod_pri = cod_s; hay_pri = hay_s;
            cod_sec = cod_b; hay_sec = hay_b;
        end
        if (PRIORIDAD_CABINA && hay_cab) begin
            res = cod_cab;
        end else if (hay_pri) begin
            res = cod_pri;
        end else if (hay_sec) begin
            res = cod_sec;
        end else if (hay_cab) begin
            res = cod_cab;
        end else begin
            res = ANCHO_COD'(0);
        end
        return res;
    endfunction

    // Lowest set bit index (nearest occupied floor above).
    function automatic logic [1:0] menor_activo(input logic [3:0] v);
        logic [1:0] r;
        casez (v)
            4'b???1: r = 2'd0;
            4'b??10: r = 2'd1;
            4'b?100: r = 2'd2;
            4'b1000: r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    // Highest set bit index (nearest occupied floor below).
    function automatic logic [1:0] mayor_activo(input logic [3:0] v);
        logic [1:0] r;
        casez (v)
            4'b1???: r = 2'd3;
            4'b01??: r = 2'd2;
            4'b001?: r = 2'd1;
            4'b0001: r = 2'd0;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] contar_unos(input logic [9:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 10; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    logic [ANCHO_COD-1:0] r_memoria;
    logic [9:0]           r_pend;
    logic [3:0]           r_n_pend;
    dir_t                 r_direccion;

    logic [9:0]           w_captura;
    logic [9:0]           w_borrado;
    logic [9:0]           w_pend_sig;
    logic [3:0]           w_ocupado;
    logic [3:0]           w_mask_arriba;
    logic [3:0]           w_mask_abajo;
    logic [3:0]           w_sobre;
    logic [3:0]           w_bajo;
    logic                 w_aqui;
    logic                 w_arriba;
    logic                 w_abajo;
    logic [ANCHO_COD-1:0] w_objetivo;
    logic [ANCHO_COD-1:0] w_memoria_sig;
    dir_t                 w_dir_sig;
    logic                 w_unused_accion;

    // accion is status only; scheduling never depends on it.
    assign w_unused_accion = &{1'b0, accion};

    // Next bitmap: capture the pressed code, then clear the serviced floor.
    // Clearing after capturing makes a press at the open floor vanish at once.
    always_comb begin
        w_captura = 10'd0;
        w_borrado = 10'd0;
        if ((boton_pres >= ANCHO_COD'(1)) && (boton_pres <= ANCHO_COD'(10))) begin
            w_captura = 10'd1 << (boton_pres - ANCHO_COD'(1));
        end else begin
            w_captura = 10'd0;
        end
        if (puertas) begin
            w_borrado = mascara_piso(piso);
        end else begin
            w_borrado = 10'd0;
        end
        w_pend_sig = (r_pend | w_captura) & ~w_borrado;
    end

    // Floor classification relative to the current floor.
    always_comb begin
        w_ocupado = 4'd0;
        for (int f = 0; f < 4; f++) begin
            w_ocupado[f] = |(r_pend & mascara_piso(2'(f)));
        end
        case (piso)
            2'd0:    begin w_mask_arriba = 4'b1110; w_mask_abajo = 4'b0000; end
            2'd1:    begin w_mask_arriba = 4'b1100; w_mask_abajo = 4'b0001; end
            2'd2:    begin w_mask_arriba = 4'b1000; w_mask_abajo = 4'b0011; end
            2'd3:    begin w_mask_arriba = 4'b0000; w_mask_abajo = 4'b0111; end
            default: begin w_mask_arriba = 4'b0000; w_mask_abajo = 4'b0000; end
        endcase
        w_sobre  = w_ocupado & w_mask_arriba;
        w_bajo   = w_ocupado & w_mask_abajo;
        w_aqui   = w_ocupado[piso];
        w_arriba = |w_sobre;
        w_abajo  = |w_bajo;
    end

    // Next-state logic: SCAN target selection and direction update.
    always_comb begin
        w_objetivo = ANCHO_COD'(0);
        w_dir_sig  = r_direccion;
        if (r_pend == 10'd0) begin
            w_objetivo = ANCHO_COD'(0);
            w_dir_sig  = DIR_REPOSO;
        end else if (w_aqui) begin
            w_objetivo = codigo_piso(r_pend, piso, r_direccion);
            w_dir_sig  = r_direccion;
        end else if ((r_direccion == DIR_SUBE) && w_arriba) begin
            w_objetivo = codigo_piso(r_pend, menor_activo(w_sobre), r_direccion);
            w_dir_sig  = r_direccion;
        end else if ((r_direccion == DIR_BAJA) && w_abajo) begin
            w_objetivo = codigo_piso(r_pend, mayor_activo(w_bajo), r_direccion);
            w_dir_sig  = r_direccion;
        end else if (w_arriba) begin
            w_objetivo = codigo_piso(r_pend, menor_activo(w_sobre), r_direccion);
            w_dir_sig  = DIR_SUBE;
        end else if (w_abajo) begin
            w_objetivo = codigo_piso(r_pend, mayor_activo(w_bajo), r_direccion);
            w_dir_sig  = DIR_BAJA;
        end else begin
            w_objetivo = ANCHO_COD'(0);
            w_dir_sig  = DIR_REPOSO;
        end
    end

    // Output logic: memoria is frozen while the state machine samples it.
    always_comb begin
        w_memoria_sig = r_memoria;
        if (LE) begin
            w_memoria_sig = w_objetivo;
        end else begin
            w_memoria_sig = r_memoria;
        end
    end

    // State register: scheduler direction, updated every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_direccion <= DIR_REPOSO;
        end else begin
            r_direccion <= w_dir_sig;
        end
    end

    // Data registers: bitmap, its popcount and the announced instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend    <= 10'd0;
            r_n_pend  <= 4'd0;
            r_memoria <= ANCHO_COD'(0);
        end else begin
            r_pend    <= w_pend_sig;
            r_n_pend  <= contar_unos(w_pend_sig);
            r_memoria <= w_memoria_sig;
        end
    end

    assign memoria      = r_memoria;
    assign pendientes   = r_pend;
    assign n_pendientes = r_n_pend;
    assign direccion    = r_direccion;

endmodule

// File: tb/tb_planificador_solicitudes.sv
module tb_planificador_solicitudes;

    localparam bit PRIO = 1'b1;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] boton_pres;
    logic       LE;
    logic [1:0] piso;
    logic [1:0] accion;
    logic       puertas;
    logic [3:0] memoria;
    logic [9:0] pendientes;
    logic [3:0] n_pendientes;
    logic [1:0] direccion;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: set of pending codes, direction, announced code.
    bit m_pend [1:10];
    int m_dir;
    int m_mem;

    planificador_solicitudes #(.PRIORIDAD_CABINA(PRIO), .ANCHO_COD(4)) dut (
        .clk(clk), .rst(rst), .boton_pres(boton_pres), .LE(LE), .piso(piso),
        .accion(accion), .puertas(puertas), .memoria(memoria),
        .pendientes(pendientes), .n_pendientes(n_pendientes), .direccion(direccion)
    );

    always #5 clk = ~clk;

    // Floor served by a code: cabin 1..4 -> 0..3, hall 5..10 -> (c-4)/2.
    function automatic int piso_de(int c);
        return (c <= 4) ? c - 1 : (c - 4) / 2;
    endfunction

    function automatic bit piso_ocupado(int f);
        for (int c = 1; c <= 10; c++) begin
            if (m_pend[c] && piso_de(c) == f) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int codigo_de(int f, int dir);
        int cab = f + 1;
        int s = (f < 3) ? 5 + 2 * f : 0;
        int b = (f > 0) ? 4 + 2 * f : 0;
        int pri, sec;
        if (PRIO && m_pend[cab]) return cab;
        if (dir == 2) begin pri = b; sec = s; end
        else begin pri = s; sec = b; end
        if (pri != 0 && m_pend[pri]) return pri;
        if (sec != 0 && m_pend[sec]) return sec;
        if (m_pend[cab]) return cab;
        return 0;
    endfunction

    function automatic logic [9:0] mapa();
        logic [9:0] v = 10'd0;
        for (int c = 1; c <= 10; c++) v[c-1] = m_pend[c];
        return v;
    endfunction

    function automatic int cuenta();
        int n = 0;
        for (int c = 1; c <= 10; c++) n += int'(m_pend[c]);
        return n;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic modelo_paso();
        int  p = int'(piso);
        int  obj = 0;
        int  nd = m_dir;
        int  arr = -1;
        int  aba = -1;
        int  btn = int'(boton_pres);
        bit  alguno = 1'b0;
        for (int c = 1; c <= 10; c++) alguno |= m_pend[c];
        for (int d = 1; d <= 3; d++) if (arr < 0 && p + d <= 3 && piso_ocupado(p + d)) arr = p + d;
        for (int d = 1; d <= 3; d++) if (aba < 0 && p - d >= 0 && piso_ocupado(p - d)) aba = p - d;
        if (!alguno) begin obj = 0; nd = 0; end
        else if (piso_ocupado(p)) obj = codigo_de(p, m_dir);
        else if (m_dir == 1 && arr >= 0) obj = codigo_de(arr, m_dir);
        else if (m_dir == 2 && aba >= 0) obj = codigo_de(aba, m_dir);
        else if (arr >= 0) begin obj = codigo_de(arr, m_dir); nd = 1; end
        else begin obj = codigo_de(aba, m_dir); nd = 2; end
        if (rst) begin
            for (int c = 1; c <= 10; c++) m_pend[c] = 1'b0;
            m_dir = 0;
            m_mem = 0;
        end else begin
            if (LE) m_mem = obj;
            m_dir = nd;
            if (btn >= 1 && btn <= 10) m_pend[btn] = 1'b1;
            if (puertas) begin
                for (int c = 1; c <= 10; c++) if (piso_de(c) == p) m_pend[c] = 1'b0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: update the model, take the edge, then compare all outputs.
    task automatic ciclo(input string tag);
        modelo_paso();
        @(posedge clk);
        #1;
        chk({tag, ".memoria"},      16'(memoria),      16'(m_mem));
        chk({tag, ".pendientes"},   16'(pendientes),   16'(mapa()));
        chk({tag, ".n_pendientes"}, 16'(n_pendientes), 16'(cuenta()));
        chk({tag, ".direccion"},    16'(direccion),    16'(m_dir));
    endtask

    initial begin
        rst = 1'b1; boton_pres = 4'd0; LE = 1'b1; piso = 2'd0; accion = 2'd0; puertas = 1'b0;
        m_dir = 0; m_mem = 0;
        for (int c = 1; c <= 10; c++) m_pend[c] = 1'b0;
        ciclo("reset0");
        rst = 1'b0;

        // Fill the whole bitmap, then reset drops it.
        for (int c = 1; c <= 10; c++) begin
            boton_pres = 4'(c);
            ciclo("llenar");
        end
        chk("lleno", 16'(pendientes), 16'h03FF);
        boton_pres = 4'd0; rst = 1'b1;
        ciclo("reset1");
        chk("rst_pend", 16'(pendientes), 16'h0000);
        chk("rst_mem",  16'(memoria),    16'h0000);
        chk("rst_dir",  16'(direccion),  16'h0000);
        chk("rst_n",    16'(n_pendientes), 16'h0000);
        rst = 1'b0;

        // Capture and two-cycle latency; invalid code ignored.
        boton_pres = 4'd3; ciclo("cap1");
        chk("cap_pend", 16'(pendientes), 16'h0004);
        boton_pres = 4'd12; ciclo("cap2");
        chk("cap_mem", 16'(memoria), 16'd3);
        chk("cap_dir", 16'(direccion), 16'd1);
        chk("cap_inval", 16'(pendientes), 16'h0004);

        // SCAN ordering.
        boton_pres = 4'd0; piso = 2'd2; puertas = 1'b1; ciclo("scan_clr");
        puertas = 1'b0; piso = 2'd1; boton_pres = 4'd4; ciclo("scan_p4");
        boton_pres = 4'd1; ciclo("scan_p1");
        boton_pres = 4'd0; ciclo("scan_up");
        chk("scan_mem4", 16'(memoria), 16'd4);
        piso = 2'd3; puertas = 1'b1; ciclo("scan_arr3");
        puertas = 1'b0; ciclo("scan_turn");
        chk("scan_mem1", 16'(memoria), 16'd1);
        chk("scan_dir2", 16'(direccion), 16'd2);

        // Hall preference follows direction.
        piso = 2'd0; puertas = 1'b1; ciclo("hall_clr");
        puertas = 1'b0; boton_pres = 4'd7; ciclo("hall_p7");
        boton_pres = 4'd6; ciclo("hall_p6");
        boton_pres = 4'd0; ciclo("hall_up");
        chk("hall_S2", 16'(memoria), 16'd7);
        piso = 2'd3; ciclo("hall_rev");
        ciclo("hall_down");
        chk("hall_B2", 16'(memoria), 16'd6);

        // LE hold.
        piso = 2'd1; puertas = 1'b1; ciclo("le_clr");
        puertas = 1'b0; piso = 2'd0; boton_pres = 4'd2; ciclo("le_p2");
        boton_pres = 4'd0; ciclo("le_sel");
        chk("le_mem2", 16'(memoria), 16'd2);
        LE = 1'b0; boton_pres = 4'd4; ciclo("le_hold1");
        chk("le_hold_mem", 16'(memoria), 16'd2);
        chk("le_hold_pend", 16'(pendientes), 16'h000A);
        boton_pres = 4'd0; piso = 2'd1; puertas = 1'b1; ciclo("le_hold2");
        puertas = 1'b0; ciclo("le_hold3");
        chk("le_hold_mem3", 16'(memoria), 16'd2);
        LE = 1'b1; ciclo("le_rel");
        chk("le_rel_mem", 16'(memoria), 16'd4);

        // Clear wins over a held button on the open floor.
        piso = 2'd2; puertas = 1'b1; boton_pres = 4'd3;
        for (int k = 0; k < 3; k++) begin
            ciclo("cv_held");
            chk("cv_bit2", 16'(pendientes[2]), 16'd0);
        end
        puertas = 1'b0; ciclo("cv_set");
        chk("cv_set_bit2", 16'(pendientes[2]), 16'd1);
        boton_pres = 4'd0; ciclo("cv_here");
        chk("cv_mem3", 16'(memoria), 16'd3);

        // Randomized operation against the model.
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 63) == 0);
            boton_pres = 4'($urandom_range(0, 15));
            LE         = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) piso = 2'($urandom_range(0, 3));
            puertas    = ($urandom_range(0, 2) == 0);
            accion     = 2'($urandom_range(0, 2));
            ciclo("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/planificador_solicitudes.md
Name: planificador_solicitudes

Overview:
- Request scheduler directly upstream of the elevator state machine. Replaces the simple request memory in front of it.
- Inputs: the encoded button code from the input encoder (0..10), plus floor, motion and door status fed back from the state machine.
- Keeps a pending-request bitmap and applies SCAN ordering (continue in the current direction while requests remain ahead).
- Presents one next-instruction code (`memoria`) that the state machine samples while `LE`=0.

Parameters:
- PRIORIDAD_CABINA, 1, at the same floor: 1 = cabin code wins over hall code; 0 = hall code wins.
- ANCHO_COD, 4, width of the button/instruction code (fixed at 4; codes 0..10 valid).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- boton_pres  in  4  button code: 0 none, 1-4 cabin floor 1-4, 5 S1, 6 B2, 7 S2, 8 B3, 9 S3, 10 B4
- LE  in  1  1 = `memoria` may update; 0 = state machine sampling, hold `memoria`
- piso  in  2  current floor, 0..3
- accion  in  2  0 stopped, 1 up, 2 down (informational, not used for scheduling)
- puertas  in  1  1 = doors open at `piso`
- memoria  out  4  next instruction code, registered
- pendientes  out  10  bitmap; bit k-1 = code k pending
- n_pendientes  out  4  popcount of `pendientes`
- direccion  out  2  scheduler direction: 0 idle, 1 up, 2 down

Behaviour:
- Reset (synchronous, rst=1 at posedge): memoria=0, pendientes=0, n_pendientes=0, direccion=0. Reset mid-operation drops all pending requests.
- Capture:
  - Each cycle, boton_pres in 1..10 sets bit boton_pres-1.
  - Codes 0 and 11..15 are ignored.
  - Setting an already-set bit has no effect.
- Service clear:
  - Each cycle puertas=1, clear cabin bit (piso+1) and both hall bits of floor `piso`.
  - Floor 0 has only S1; floor 3 has only B4.
  - Same bit set and cleared in the same cycle: clear wins. A held button re-sets the bit the next cycle.
- Floor classification, computed combinationally from registered `pendientes` and `piso`:
  - here = any bit of floor `piso`
  - above = any bit of a floor > piso
  - below = any bit of a floor < piso
- Floor code choice for a target floor f:
  - Cabin code f+1 if set and PRIORIDAD_CABINA=1.
  - Otherwise the hall code of f: S preferred when direccion is up/idle, B when down. Fall back to whichever is set.
- Target selection, in priority order:
  1. No pending bits: target code 0, direccion becomes 0.
  2. here: code of floor `piso`, direccion unchanged.
  3. direccion=1 and above: nearest floor above.
  4. direccion=2 and below: nearest floor below.
  5. above: nearest floor above, direccion becomes 1.
  6. below: nearest floor below, direccion becomes 2.
  - In cases 3 and 4, direccion is kept.
- memoria update:
  - Registered: takes the selected code on the posedge where LE=1.
  - LE=0: memoria holds its value. `pendientes` and `direccion` still update.
- Latency: button present at edge N → bit visible after edge N → memoria updated at edge N+1 (if LE=1), i.e. 2 cycles.
- Outputs:
  - `n_pendientes` is registered alongside `pendientes`; maximum value 10.
  - `direccion` updates every cycle regardless of LE.
- Simultaneous events: a new request on the current floor while doors are open is cleared immediately (no re-open). Clear takes precedence over capture.

Test Plan:
- Reset: pulse rst with pendientes=0x3FF → after one edge pendientes=0, memoria=0, direccion=0, n_pendientes=0.
- Capture and latency: piso=0, LE=1, boton_pres=3 for 1 cycle → pendientes=0x004 after edge 1; memoria=3 and direccion=1 after edge 2; boton_pres=12 → no change.
- SCAN ordering: piso=1, direccion=1, pending codes 1 and 4 → memoria=4. With piso=3, puertas=1: bit 3 clears, then memoria=1 and direccion=2.
- Hall preference: piso=0, direccion=1, pending 7 (S2) and 6 (B2) → memoria=7. Same bitmap with piso=3, direccion=2 → memoria=6.
- LE hold: memoria=2, LE=0, new request code 4 → memoria stays 2 while pendientes shows bit 3. LE=1 → memoria updates next edge.
- Clear vs set: piso=2, puertas=1, boton_pres=3 held → bit 2 never observed set. puertas=0 → bit 2 set next cycle; memoria=3 (here).
